// File: rtl/cnn_frame_streamer.sv
// Frame streamer feeding the 3x3 binary-window convolver.
// Holds one IMG_W x IMG_H binary image (written row by row while idle) and,
// on Start, serializes it in raster order followed by one zero flush beat.
// Cal_Valid fires one cycle after the beat that follows an interior pixel.
// Ports:
//   clk, rst_n          clock / async active-low reset
//   Wr_En/Wr_Addr/Wr_Data  row write port (ignored while busy or out of range)
//   Start               single-cycle frame start (ignored while busy)
//   Hold                downstream stall; freezes the pixel index
//   Din/Din_Valid       serialized pixel and its qualifier
//   Cal_Valid           convolver window is a complete interior 3x3 window
//   Busy/Done           streaming in progress / end-of-frame pulse
module cnn_frame_streamer #(
    parameter int unsigned IMG_W  = 34,
    parameter int unsigned IMG_H  = 34,
    parameter int unsigned ROW_AW = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Wr_En,
    input  logic [ROW_AW-1:0] Wr_Addr,
    input  logic [IMG_W-1:0]  Wr_Data,
    input  logic              Start,
    input  logic              Hold,
    output logic              Din,
    output logic              Din_Valid,
    output logic              Cal_Valid,
    output logic              Busy,
    output logic              Done
);

    localparam int unsigned TOTAL = IMG_W * IMG_H;
    localparam int unsigned PW    = $clog2(TOTAL + 1);
    localparam int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_TAIL   = 2'd2;

    logic [1:0]        r_state, w_state_nxt;
    logic [PW-1:0]     r_p, w_p_nxt;
    logic [ROW_AW-1:0] r_row, w_row_nxt;
    logic [CW-1:0]     r_col, w_col_nxt;
    logic              r_prev_int, w_prev_int_nxt;
    logic              r_cal_pend, w_cal_pend_nxt;
    logic              r_flushed, w_flushed_nxt;
    logic              r_din, w_din_nxt;
    logic              r_din_valid, w_din_valid_nxt;
    logic              r_cal_valid, w_cal_valid_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;

    logic [IMG_W-1:0]  r_mem [IMG_H];
    logic              w_wr_ok;
    logic              w_pix;
    logic              w_row_ok;
    logic              w_last_col;

    // Row writes are accepted only while idle and for in-range rows.
    assign w_wr_ok = (r_state == S_IDLE) && Wr_En && (32'(Wr_Addr) < IMG_H);

    // Image memory is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[Wr_Addr] <= Wr_Data;
        end
    end

    assign w_row_ok   = (32'(r_row) < IMG_H);
    assign w_pix      = w_row_ok ? r_mem[r_row][r_col] : 1'b0;
    assign w_last_col = (32'(r_col) == IMG_W - 1);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_p_nxt         = r_p;
        w_row_nxt       = r_row;
        w_col_nxt       = r_col;
        w_prev_int_nxt  = r_prev_int;
        w_cal_pend_nxt  = 1'b0;
        w_flushed_nxt   = r_flushed;
        w_din_nxt       = r_din;
        w_din_valid_nxt = 1'b0;
        w_cal_valid_nxt = r_cal_pend;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_state_nxt    = S_STREAM;
                    w_busy_nxt     = 1'b1;
                    w_p_nxt        = '0;
                    w_row_nxt      = '0;
                    w_col_nxt      = '0;
                    w_prev_int_nxt = 1'b0;
                    w_flushed_nxt  = 1'b0;
                end
            end
            S_STREAM: begin
                if (r_flushed) begin
                    // Cal_Valid of the flush beat is registered on this edge.
                    w_state_nxt = S_TAIL;
                end else if (!Hold) begin
                    w_din_valid_nxt = 1'b1;
                    // The beat carrying p completes the window ending at p-1.
                    w_cal_pend_nxt  = r_prev_int;
                    if (32'(r_p) == TOTAL) begin
                        w_din_nxt     = 1'b0;
                        w_flushed_nxt = 1'b1;
                    end else begin
                        w_din_nxt      = w_pix;
                        w_prev_int_nxt = (32'(r_row) >= 2) && (32'(r_col) >= 2);
                        w_p_nxt        = r_p + PW'(1);
                        if (w_last_col) begin
                            w_col_nxt = '0;
                            w_row_nxt = r_row + ROW_AW'(1);
                        end else begin
                            w_col_nxt = r_col + CW'(1);
                        end
                    end
                end
            end
            S_TAIL: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_p         <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_prev_int  <= 1'b0;
            r_cal_pend  <= 1'b0;
            r_flushed   <= 1'b0;
            r_din       <= 1'b0;
            r_din_valid <= 1'b0;
            r_cal_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_p         <= w_p_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_prev_int  <= w_prev_int_nxt;
            r_cal_pend  <= w_cal_pend_nxt;
            r_flushed   <= w_flushed_nxt;
            r_din       <= w_din_nxt;
            r_din_valid <= w_din_valid_nxt;
            r_cal_valid <= w_cal_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign Din       = r_din;
    assign Din_Valid = r_din_valid;
    assign Cal_Valid = r_cal_valid;
    assign Busy      = r_busy;
    assign Done      = r_done;

endmodule

// File: tb/tb_cnn_frame_streamer.sv
// Directed testbench for cnn_frame_streamer at default 34x34 geometry.
module tb_cnn_frame_streamer;

    localparam int W     = 34;
    localparam int H     = 34;
    localparam int TOTAL = W * H;
    localparam int NINT  = (W - 2) * (H - 2);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         Wr_En = 1'b0;
    logic [5:0]   Wr_Addr = '0;
    logic [W-1:0] Wr_Data = '0;
    logic         Start = 1'b0;
    logic         Hold = 1'b0;
    logic         Din, Din_Valid, Cal_Valid, Busy, Done;

    cnn_frame_streamer #(.IMG_W(W), .IMG_H(H), .ROW_AW(6)) dut (
        .clk(clk), .rst_n(rst_n), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr),
        .Wr_Data(Wr_Data), .Start(Start), .Hold(Hold), .Din(Din),
        .Din_Valid(Din_Valid), .Cal_Valid(Cal_Valid), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference image as the bench believes it is loaded.
    logic [W-1:0] img [H];

    // Monitor state.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit         mon_en = 1'b0;
    int         nbeats, ncal, ndone, t0, busy_rise, done_cyc, last_beat_cyc;
    int         cal_late, win_err, start_cyc;
    logic       beats [0:1199];
    int         cal_cyc [0:1099];
    logic [2*W+2:0] win;
    int         cand;

    function automatic int win_gold(input int k);
        int r, c, s;
        r = 2 + k / (W - 2);
        c = 2 + k % (W - 2);
        s = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                s += int'(img[r-dr][c-dc]);
        return s;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (Busy && busy_rise < 0) busy_rise = cyc;
            if (Cal_Valid) begin
                if (ncal < 1100) cal_cyc[ncal] = cyc;
                if (last_beat_cyc != cyc - 1) cal_late++;
                if (ncal < NINT && cand != win_gold(ncal)) win_err++;
                ncal++;
            end
            if (Din_Valid) begin
                if (t0 < 0) t0 = cyc;
                if (nbeats < 1200) beats[nbeats] = Din;
                nbeats++;
                last_beat_cyc = cyc;
                // Window ending at the previous beat, newest in win[0].
                cand = 0;
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        cand += int'(win[dr*W+dc]);
                win = {win[2*W+1:0], Din};
            end
            if (Done) begin
                ndone++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_mon();
        nbeats = 0; ncal = 0; ndone = 0; t0 = -1; busy_rise = -1;
        done_cyc = -1; last_beat_cyc = -10; cal_late = 0; win_err = 0;
        cand = 0; win = '0;
    endtask

    function automatic int seq_mismatch();
        int m;
        logic e;
        m = 0;
        if (nbeats != TOTAL + 1) m++;
        for (int i = 0; i <= TOTAL && i < nbeats; i++) begin
            e = (i < TOTAL) ? img[i/W][i%W] : 1'b0;
            if (beats[i] !== e) m++;
        end
        return m;
    endfunction

    function automatic int cal_time_mismatch();
        int m, q;
        m = 0;
        for (int k = 0; k < ncal && k < 1100; k++) begin
            q = (2 + k / (W - 2)) * W + 2 + k % (W - 2);
            if (cal_cyc[k] != t0 + q + 2) m++;
        end
        return m;
    endfunction

    task automatic write_row(input int r, input logic [W-1:0] d);
        @(negedge clk);
        Wr_En = 1'b1; Wr_Addr = 6'(r); Wr_Data = d;
        @(negedge clk);
        Wr_En = 1'b0;
        if (r < H) img[r] = d;
    endtask

    // Starts a frame and runs until Done; optionally pokes writes/Start mid-frame.
    task automatic run_frame(input int hold_pct, input bit poke,
                             input logic [W-1:0] poke_data, output bit timeout);
        clear_mon();
        mon_en = 1'b1;
        @(negedge clk);
        Start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        Start = 1'b0;
        timeout = 1'b1;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            Hold = (int'($urandom_range(0, 99)) < hold_pct);
            if (poke) begin
                Wr_En   = (n == 100);
                Wr_Addr = 6'd5;
                Wr_Data = poke_data;
                Start   = (n == 101);
            end
            if (ndone > 0) begin
                timeout = 1'b0;
                break;
            end
        end
        Hold = 1'b0; Wr_En = 1'b0; Start = 1'b0;
        repeat (20) @(negedge clk);
        mon_en = 1'b0;
        if (timeout) begin
            errors++;
            $display("FAIL frame_timeout beats=%0d required Done within budget", nbeats);
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({Din, Din_Valid, Cal_Valid, Busy, Done} !== 5'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_idle nonzero_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_zero_frame();
        bit to;
        for (int r = 0; r < H; r++) write_row(r, '0);
        run_frame(0, 1'b0, '0, to);
        checks++;
        if (busy_rise != start_cyc + 1) begin
            errors++;
            $display("FAIL busy_rise got=%0d required=%0d", busy_rise, start_cyc + 1);
        end
        checks++;
        if (t0 != start_cyc + 2) begin
            errors++;
            $display("FAIL first_beat got=%0d required=%0d", t0, start_cyc + 2);
        end
        checks++;
        if (nbeats != TOTAL + 1) begin
            errors++;
            $display("FAIL zero_beats got=%0d required=%0d", nbeats, TOTAL + 1);
        end
        checks++;
        if (ncal != NINT) begin
            errors++;
            $display("FAIL zero_cal_count got=%0d required=%0d", ncal, NINT);
        end
        checks++;
        if (cal_cyc[0] - t0 != 72) begin
            errors++;
            $display("FAIL first_cal got=T0+%0d required=T0+72", cal_cyc[0] - t0);
        end
        checks++;
        if (cal_time_mismatch() != 0) begin
            errors++;
            $display("FAIL cal_timing mismatches=%0d required 0", cal_time_mismatch());
        end
        checks++;
        if (ncal > 0 && cal_cyc[ncal-1] - t0 != 1157) begin
            errors++;
            $display("FAIL last_cal got=T0+%0d required=T0+1157", cal_cyc[ncal-1] - t0);
        end
        checks++;
        if (ndone != 1 || done_cyc - t0 != 1158) begin
            errors++;
            $display("FAIL done got_count=%0d at T0+%0d required 1 at T0+1158",
                     ndone, done_cyc - t0);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_done got=%b required 0", Busy);
        end
    endtask

    task automatic test_checkerboard();
        bit to;
        logic [W-1:0] base;
        base = 34'h2AAAAAAAA;
        for (int r = 0; r < H; r++) write_row(r, base << (r % 2));
        write_row(40, {W{1'b1}});
        run_frame(0, 1'b0, '0, to);
        checks++;
        if (seq_mismatch() != 0) begin
            errors++;
            $display("FAIL checker_seq mismatches=%0d required 0", seq_mismatch());
        end
        checks++;
        if (win_err != 0 || ncal != NINT) begin
            errors++;
            $display("FAIL checker_conv win_err=%0d cal=%0d required 0 and %0d",
                     win_err, ncal, NINT);
        end
    endtask

    task automatic test_hold();
        bit to;
        write_row(7, 34'h3_1234_5678);
        write_row(20, 34'h1_F0F0_0FF3);
        run_frame(30, 1'b0, '0, to);
        checks++;
        if (seq_mismatch() != 0) begin
            errors++;
            $display("FAIL hold_seq mismatches=%0d required 0", seq_mismatch());
        end
        checks++;
        if (ncal != NINT) begin
            errors++;
            $display("FAIL hold_cal_count got=%0d required=%0d", ncal, NINT);
        end
        checks++;
        if (cal_late != 0) begin
            errors++;
            $display("FAIL hold_cal_after_beat late=%0d required 0", cal_late);
        end
        checks++;
        if (win_err != 0) begin
            errors++;
            $display("FAIL hold_conv win_err=%0d required 0", win_err);
        end
    endtask

    task automatic test_busy_ignore();
        bit to;
        logic [W-1:0] newrow;
        newrow = 34'h2_DEAD_BEEF;
        run_frame(0, 1'b1, newrow, to);
        checks++;
        if (seq_mismatch() != 0 || ndone != 1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore seq_mm=%0d done=%0d busy=%b required 0,1,0",
                     seq_mismatch(), ndone, Busy);
        end
        // Write and Start in the same idle cycle: frame must include the write.
        img[5] = newrow;
        clear_mon();
        mon_en = 1'b1;
        @(negedge clk);
        Wr_En = 1'b1; Wr_Addr = 6'd5; Wr_Data = newrow; Start = 1'b1;
        @(negedge clk);
        Wr_En = 1'b0; Start = 1'b0;
        for (int n = 0; n < 3000 && ndone == 0; n++) @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (seq_mismatch() != 0 || ncal != NINT) begin
            errors++;
            $display("FAIL rewrite_row5 seq_mm=%0d cal=%0d required 0,%0d",
                     seq_mismatch(), ncal, NINT);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        clear_mon();
        mon_en = 1'b1;
        @(negedge clk);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        for (int n = 0; n < 3000 && nbeats < 500; n++) @(negedge clk);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({Din, Din_Valid, Cal_Valid, Busy, Done} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset outputs=%b required 00000",
                     {Din, Din_Valid, Cal_Valid, Busy, Done});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(0, 1'b0, '0, to);
        checks++;
        if (seq_mismatch() != 0 || t0 != start_cyc + 2) begin
            errors++;
            $display("FAIL restream seq_mm=%0d t0=%0d required 0,%0d",
                     seq_mismatch(), t0, start_cyc + 2);
        end
        checks++;
        if (ncal != NINT || win_err != 0) begin
            errors++;
            $display("FAIL restream_cal got=%0d win_err=%0d required %0d,0",
                     ncal, win_err, NINT);
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_checkerboard();
        test_hold();
        test_busy_ignore();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
